// File: rtl/fpgart_pkg.sv
// Shared types and defaults for the cell painter: FSM state encoding,
// colour type and the default screen geometry.
package fpgart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PAINT = 2'd1,
        ST_CLEAR = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef logic [2:0] colour_t;

    localparam int      DEF_SCREEN_WIDTH  = 320;
    localparam int      DEF_SCREEN_HEIGHT = 240;
    localparam int      DEF_CELL_SIZE     = 4;
    localparam colour_t DEF_CLEAR_COLOUR  = 3'b111;

endpackage

// File: rtl/raster_counter.sv
// Row-major 2-D counter (x fastest) with load, enable and a run-time extent
// captured on load; reports the coordinate it steps to and a last flag.
module raster_counter #(
    parameter int XW = 9,
    parameter int YW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          enable,
    input  logic [XW-1:0] width,
    input  logic [YW-1:0] height,
    output logic [XW-1:0] x_next,
    output logic [YW-1:0] y_next,
    output logic          last
);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [XW-1:0] w_q, w_d;
    logic [YW-1:0] h_q, h_d;
    logic          row_end;

    always_comb begin
        row_end = (x_q == w_q - 1'b1);
        last    = row_end && (y_q == h_q - 1'b1);
        x_next  = x_q + 1'b1;
        y_next  = y_q;
        if (row_end) begin
            x_next = '0;
            y_next = last ? '0 : y_q + 1'b1;
        end
    end

    // Load restarts at the origin; the extent is frozen for the whole sweep.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        w_d = w_q;
        h_d = h_q;
        if (load) begin
            x_d = '0;
            y_d = '0;
            w_d = width;
            h_d = height;
        end else if (enable) begin
            x_d = x_next;
            y_d = y_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
            w_q <= '0;
            h_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            w_q <= w_d;
            h_q <= h_d;
        end
    end

endmodule

// File: rtl/cell_painter.sv
// Fills one CELL_SIZE x CELL_SIZE cell, or sweeps the whole screen with
// CLEAR_COLOUR, emitting one registered pixel write per clock.
module cell_painter
    import fpgart_pkg::*;
#(
    parameter int          SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
    parameter int          SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
    parameter int          CELL_SIZE     = DEF_CELL_SIZE,
    parameter logic [2:0]  CLEAR_COLOUR  = DEF_CLEAR_COLOUR
) (
    input  logic       iClk,
    input  logic       iResetn,
    input  logic       iPaintReq,
    input  logic       iClearReq,
    input  logic [7:0] iX_cell,
    input  logic [7:0] iY_cell,
    input  logic [2:0] iColour,
    output logic       oReady,
    output logic [8:0] oX_pixel,
    output logic [7:0] oY_pixel,
    output logic [2:0] oColour,
    output logic       oPlot,
    output logic       oDone,
    output logic [1:0] oDbgState
);

    localparam int         CELL_SHIFT = $clog2(CELL_SIZE);
    localparam int         CELLS_X    = SCREEN_WIDTH / CELL_SIZE;
    localparam int         CELLS_Y    = SCREEN_HEIGHT / CELL_SIZE;
    localparam logic [8:0] CLEAR_W    = 9'(SCREEN_WIDTH);
    localparam logic [7:0] CLEAR_H    = 8'(SCREEN_HEIGHT);
    localparam logic [8:0] CELL_W     = 9'(CELL_SIZE);
    localparam logic [7:0] CELL_H     = 8'(CELL_SIZE);

    state_e     state_q, state_d;
    logic [8:0] base_x_q, base_x_d;
    logic [7:0] base_y_q, base_y_d;
    colour_t    colour_q, colour_d;

    logic       ready_q, ready_d;
    logic [8:0] x_q, x_d;
    logic [7:0] y_q, y_d;
    colour_t    col_q, col_d;
    logic       plot_q, plot_d;
    logic       done_q, done_d;

    logic       cnt_load, cnt_en;
    logic [8:0] cnt_w;
    logic [7:0] cnt_h;
    logic [8:0] cnt_x_next;
    logic [7:0] cnt_y_next;
    logic       cnt_last;

    logic [8:0] req_base_x;
    logic [7:0] req_base_y;
    logic       req_valid;

    raster_counter #(
        .XW(9),
        .YW(8)
    ) u_raster (
        .clk    (iClk),
        .rst_n  (iResetn),
        .load   (cnt_load),
        .enable (cnt_en),
        .width  (cnt_w),
        .height (cnt_h),
        .x_next (cnt_x_next),
        .y_next (cnt_y_next),
        .last   (cnt_last)
    );

    // Out-of-range cells may wrap here; they never reach the outputs.
    always_comb begin
        req_base_x = {1'b0, iX_cell} << CELL_SHIFT;
        req_base_y = iY_cell << CELL_SHIFT;
        req_valid  = ({24'd0, iX_cell} < 32'(CELLS_X)) &&
                     ({24'd0, iY_cell} < 32'(CELLS_Y));
    end

    // Handshake: a request is taken only on a clock where oReady=1 and the
    // request bit is high (clear beats paint); requests while busy are dropped.
    // The first pixel of an accepted job is registered on the accepting edge.
    always_comb begin
        state_d  = state_q;
        base_x_d = base_x_q;
        base_y_d = base_y_q;
        colour_d = colour_q;
        x_d      = x_q;
        y_d      = y_q;
        col_d    = col_q;
        plot_d   = 1'b0;
        done_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        cnt_w    = CELL_W;
        cnt_h    = CELL_H;

        case (state_q)
            ST_IDLE: begin
                if (iClearReq) begin
                    state_d  = ST_CLEAR;
                    base_x_d = '0;
                    base_y_d = '0;
                    colour_d = CLEAR_COLOUR;
                    cnt_load = 1'b1;
                    cnt_w    = CLEAR_W;
                    cnt_h    = CLEAR_H;
                    x_d      = '0;
                    y_d      = '0;
                    col_d    = CLEAR_COLOUR;
                    plot_d   = 1'b1;
                end else if (iPaintReq) begin
                    base_x_d = req_base_x;
                    base_y_d = req_base_y;
                    colour_d = iColour;
                    if (req_valid) begin
                        state_d  = ST_PAINT;
                        cnt_load = 1'b1;
                        x_d      = req_base_x;
                        y_d      = req_base_y;
                        col_d    = iColour;
                        plot_d   = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_PAINT, ST_CLEAR: begin
                if (cnt_last) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                    x_d    = base_x_q + cnt_x_next;
                    y_d    = base_y_q + cnt_y_next;
                    col_d  = colour_q;
                    plot_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge iClk or negedge iResetn) begin
        if (!iResetn) begin
            state_q  <= ST_IDLE;
            base_x_q <= '0;
            base_y_q <= '0;
            colour_q <= '0;
            ready_q  <= 1'b1;
            x_q      <= '0;
            y_q      <= '0;
            col_q    <= '0;
            plot_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_x_q <= base_x_d;
            base_y_q <= base_y_d;
            colour_q <= colour_d;
            ready_q  <= ready_d;
            x_q      <= x_d;
            y_q      <= y_d;
            col_q    <= col_d;
            plot_q   <= plot_d;
            done_q   <= done_d;
        end
    end

    assign oReady    = ready_q;
    assign oX_pixel  = x_q;
    assign oY_pixel  = y_q;
    assign oColour   = col_q;
    assign oPlot     = plot_q;
    assign oDone     = done_q;
    assign oDbgState = state_q;

endmodule

// File: tb/tb_cell_painter.sv
// Directed bench for cell_painter at 320x240, CELL_SIZE=4: paint, range
// boundaries, clear with simultaneous requests, busy drops and reset abort.
module tb_cell_painter;
    import fpgart_pkg::*;

    logic       iClk;
    logic       iResetn;
    logic       iPaintReq;
    logic       iClearReq;
    logic [7:0] iX_cell;
    logic [7:0] iY_cell;
    logic [2:0] iColour;
    logic       oReady;
    logic [8:0] oX_pixel;
    logic [7:0] oY_pixel;
    logic [2:0] oColour;
    logic       oPlot;
    logic       oDone;
    logic [1:0] oDbgState;

    int n_pass;
    int n_total;
    int n_fail;
    int bad;
    int first_bad;
    int dones;
    int cycles;

    cell_painter dut (
        .iClk      (iClk),
        .iResetn   (iResetn),
        .iPaintReq (iPaintReq),
        .iClearReq (iClearReq),
        .iX_cell   (iX_cell),
        .iY_cell   (iY_cell),
        .iColour   (iColour),
        .oReady    (oReady),
        .oX_pixel  (oX_pixel),
        .oY_pixel  (oY_pixel),
        .oColour   (oColour),
        .oPlot     (oPlot),
        .oDone     (oDone),
        .oDbgState (oDbgState)
    );

    initial iClk = 1'b0;
    always #10 iClk = ~iClk;

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One paint job; disturb changes the inputs and pulses clear while busy.
    task automatic run_paint(input string tag, input logic [7:0] cx, input logic [7:0] cy,
                             input logic [2:0] col, input logic [8:0] px, input logic [7:0] py,
                             input bit disturb);
        iX_cell   = cx;
        iY_cell   = cy;
        iColour   = col;
        iPaintReq = 1'b1;
        check({tag, "_ready_pre"}, 32'(oReady), 32'd1);
        step();
        iPaintReq = 1'b0;
        if (disturb) begin
            iX_cell   = cx + 8'd7;
            iY_cell   = cy + 8'd1;
            iColour   = ~col;
            iClearReq = 1'b1;
            iPaintReq = 1'b1;
        end
        for (int i = 0; i < 16; i++) begin
            check({tag, "_plot"}, 32'(oPlot), 32'd1);
            check({tag, "_x"}, 32'(oX_pixel), 32'(px + 9'(i % 4)));
            check({tag, "_y"}, 32'(oY_pixel), 32'(py + 8'(i / 4)));
            check({tag, "_col"}, 32'(oColour), 32'(col));
            check({tag, "_ready_busy"}, 32'(oReady), 32'd0);
            if (i == 8) begin
                iClearReq = 1'b0;
                iPaintReq = 1'b0;
            end
            step();
        end
        check({tag, "_done_plot"}, 32'(oPlot), 32'd0);
        check({tag, "_done"}, 32'(oDone), 32'd1);
        check({tag, "_done_ready"}, 32'(oReady), 32'd0);
        check({tag, "_hold_x"}, 32'(oX_pixel), 32'(px + 9'd3));
        check({tag, "_hold_y"}, 32'(oY_pixel), 32'(py + 8'd3));
        check({tag, "_state_done"}, 32'(oDbgState), 32'(ST_DONE));
        step();
        check({tag, "_idle_done"}, 32'(oDone), 32'd0);
        check({tag, "_idle_ready"}, 32'(oReady), 32'd1);
        check({tag, "_idle_plot"}, 32'(oPlot), 32'd0);
    endtask

    task automatic run_invalid(input string tag, input logic [7:0] cx, input logic [7:0] cy);
        iX_cell   = cx;
        iY_cell   = cy;
        iColour   = 3'b010;
        iPaintReq = 1'b1;
        step();
        iPaintReq = 1'b0;
        check({tag, "_plot"}, 32'(oPlot), 32'd0);
        check({tag, "_done"}, 32'(oDone), 32'd1);
        check({tag, "_ready"}, 32'(oReady), 32'd0);
        step();
        check({tag, "_plot2"}, 32'(oPlot), 32'd0);
        check({tag, "_done2"}, 32'(oDone), 32'd0);
        check({tag, "_ready2"}, 32'(oReady), 32'd1);
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        n_fail    = 0;
        iResetn   = 1'b0;
        iPaintReq = 1'b0;
        iClearReq = 1'b0;
        iX_cell   = 8'd0;
        iY_cell   = 8'd0;
        iColour   = 3'd0;

        // Reset state
        repeat (3) @(posedge iClk);
        #1;
        check("rst_plot_in", 32'(oPlot), 32'd0);
        iResetn = 1'b1;
        step();
        check("rst_ready", 32'(oReady), 32'd1);
        check("rst_plot", 32'(oPlot), 32'd0);
        check("rst_done", 32'(oDone), 32'd0);
        check("rst_x", 32'(oX_pixel), 32'd0);
        check("rst_y", 32'(oY_pixel), 32'd0);
        check("rst_col", 32'(oColour), 32'd0);
        check("rst_state", 32'(oDbgState), 32'(ST_IDLE));

        // Cell (2,3) -> x 8..11, y 12..15
        run_paint("paint_2_3", 8'd2, 8'd3, 3'b100, 9'd8, 8'd12, 1'b0);

        // Inputs changed and clear pulsed while busy: latched job, no extra work
        run_paint("paint_dist", 8'd10, 8'd20, 3'b011, 9'd40, 8'd80, 1'b1);
        step();
        check("dist_no_plot", 32'(oPlot), 32'd0);
        check("dist_ready", 32'(oReady), 32'd1);

        // Range boundaries
        run_invalid("inv_x80", 8'd80, 8'd0);
        run_invalid("inv_y60", 8'd0, 8'd60);
        run_invalid("inv_255", 8'd255, 8'd255);
        run_paint("paint_79_59", 8'd79, 8'd59, 3'b001, 9'd316, 8'd236, 1'b0);

        // Reset at the fifth plot of a paint
        iX_cell   = 8'd1;
        iY_cell   = 8'd1;
        iColour   = 3'b010;
        iPaintReq = 1'b1;
        step();
        iPaintReq = 1'b0;
        repeat (4) step();
        check("abort_pre_plot", 32'(oPlot), 32'd1);
        check("abort_pre_x", 32'(oX_pixel), 32'd4);
        check("abort_pre_y", 32'(oY_pixel), 32'd5);
        #1 iResetn = 1'b0;
        #1;
        check("abort_plot_now", 32'(oPlot), 32'd0);
        check("abort_done_now", 32'(oDone), 32'd0);
        repeat (2) @(posedge iClk);
        #1 iResetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("abort_plot_after", 32'(oPlot), 32'd0);
            check("abort_done_after", 32'(oDone), 32'd0);
            check("abort_ready_after", 32'(oReady), 32'd1);
        end

        // Clear and paint together: clear wins, later requests while busy dropped
        iPaintReq = 1'b1;
        iClearReq = 1'b1;
        iX_cell   = 8'd5;
        iY_cell   = 8'd5;
        iColour   = 3'b001;
        step();
        cycles    = 1;
        iPaintReq = 1'b0;
        iClearReq = 1'b0;
        check("clear_state", 32'(oDbgState), 32'(ST_CLEAR));
        bad       = 0;
        first_bad = -1;
        dones     = 0;
        for (int i = 0; i < 76800; i++) begin
            if (!(oPlot === 1'b1 && oX_pixel === 9'(i % 320) &&
                  oY_pixel === 8'(i / 320) && oColour === 3'b111 && oReady === 1'b0)) begin
                if (bad == 0) first_bad = i;
                bad++;
            end
            if (oDone !== 1'b0) dones++;
            if (i == 100) iPaintReq = 1'b1;
            if (i == 104) begin
                iPaintReq = 1'b0;
                iClearReq = 1'b1;
            end
            if (i == 108) iClearReq = 1'b0;
            step();
            cycles++;
        end
        check("clear_pixel_errs", 32'(bad), 32'd0);
        check("clear_first_bad", 32'(first_bad), 32'hffff_ffff);
        check("clear_early_done", 32'(dones), 32'd0);
        check("clear_done", 32'(oDone), 32'd1);
        check("clear_done_plot", 32'(oPlot), 32'd0);
        check("clear_done_ready", 32'(oReady), 32'd0);
        check("clear_hold_x", 32'(oX_pixel), 32'd319);
        check("clear_hold_y", 32'(oY_pixel), 32'd239);
        step();
        cycles++;
        check("clear_cycles", 32'(cycles), 32'd76802);
        check("clear_ready", 32'(oReady), 32'd1);
        check("clear_done_end", 32'(oDone), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("clear_no_paint", 32'(oPlot), 32'd0);
            check("clear_idle_done", 32'(oDone), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
